// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared constants, IF/ID bus layout and FSM state encoding
//               for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam logic [29:0] c_RESET_PC = 30'h2FF00000;
    localparam logic [29:0] c_EXC_PC   = 30'h2FF000E0;

    localparam int c_IF_ID_W = 62;
    localparam int c_INS_HI  = 61;
    localparam int c_INS_LO  = 30;
    localparam int c_PC_HI   = 29;
    localparam int c_PC_LO   = 0;

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_CANCEL = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory port, redirect inputs and IF/ID handoff
//               of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                 inst_req;
    logic [31:0]          inst_addr;
    logic                 inst_addr_ok;
    logic [31:0]          inst_rdata;
    logic                 inst_data_ok;
    logic                 br_valid;
    logic [29:0]          br_target;
    logic                 exc_valid;
    logic                 eret_valid;
    logic [31:0]          epc;
    logic                 id_allowin;
    logic                 if_valid;
    logic [c_IF_ID_W-1:0] IF_ID_BUS;
    logic                 if_adel;

    modport master (
        output inst_req, inst_addr, if_valid, IF_ID_BUS, if_adel,
        input  inst_addr_ok, inst_rdata, inst_data_ok,
        input  br_valid, br_target, exc_valid, eret_valid, epc, id_allowin
    );

    modport slave (
        input  inst_req, inst_addr, if_valid, IF_ID_BUS, if_adel,
        output inst_addr_ok, inst_rdata, inst_data_ok,
        output br_valid, br_target, exc_valid, eret_valid, epc, id_allowin
    );

endinterface
`default_nettype wire

// File: rtl/fetch_redirect_sel.sv
`default_nettype none
// ============================================================================
// Module      : fetch_redirect_sel
// Description : Priority select of exception / ERET / branch redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_sel
    import fetch_stage_pkg::*;
#(
    parameter logic [29:0] EXC_PC = c_EXC_PC
) (
    input  wire logic        i_exc_valid,
    input  wire logic        i_eret_valid,
    input  wire logic [31:0] i_epc,
    input  wire logic        i_br_valid,
    input  wire logic [29:0] i_br_target,
    output logic             o_redir_valid,
    output logic [29:0]      o_redir_target,
    output logic             o_redir_misalign
);

    always_comb begin
        o_redir_valid    = i_exc_valid | i_eret_valid | i_br_valid;
        o_redir_target   = i_br_target;
        o_redir_misalign = 1'b0;
        if (i_exc_valid) begin
            o_redir_target = EXC_PC;
        end else if (i_eret_valid) begin
            o_redir_target   = i_epc[31:2];
            o_redir_misalign = |i_epc[1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : MIPS IF stage: PC, single-outstanding I-mem port, redirects
//               and a one-entry IF/ID buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [29:0] RESET_PC = c_RESET_PC,
    parameter logic [29:0] EXC_PC   = c_EXC_PC
) (
    input  wire logic     clk,
    input  wire logic     resetn,
    fetch_stage_if.master fetch
);

    logic                 w_redir_valid;
    logic [29:0]          w_redir_target;
    logic                 w_redir_misalign;
    logic                 w_can_fill;
    logic                 w_inst_req;
    logic                 w_addr_hs;

    fetch_state_e         state_q, state_d;
    logic [29:0]          pc_q, pc_d;
    logic                 if_valid_q, if_valid_d;
    logic [c_IF_ID_W-1:0] if_id_q, if_id_d;
    logic                 if_adel_q, if_adel_d;
    // pc_q came from a misaligned ERET; adel_sent_q marks its error entry as issued
    logic                 misalign_q, misalign_d;
    logic                 adel_sent_q, adel_sent_d;

    fetch_redirect_sel #(
        .EXC_PC (EXC_PC)
    ) u_redirect_sel (
        .i_exc_valid      (fetch.exc_valid),
        .i_eret_valid     (fetch.eret_valid),
        .i_epc            (fetch.epc),
        .i_br_valid       (fetch.br_valid),
        .i_br_target      (fetch.br_target),
        .o_redir_valid    (w_redir_valid),
        .o_redir_target   (w_redir_target),
        .o_redir_misalign (w_redir_misalign)
    );

    assign w_can_fill = !if_valid_q || fetch.id_allowin;
    assign w_inst_req = resetn && (state_q == S_REQ) && !misalign_q && w_can_fill;
    assign w_addr_hs  = w_inst_req && fetch.inst_addr_ok;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        if_valid_d  = if_valid_q;
        if_id_d     = if_id_q;
        if_adel_d   = if_adel_q;
        misalign_d  = misalign_q;
        adel_sent_d = adel_sent_q;

        if (if_valid_q && fetch.id_allowin) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (w_addr_hs) begin
                    state_d = w_redir_valid ? S_CANCEL : S_WAIT;
                end else if (misalign_q && !adel_sent_q && w_can_fill && !w_redir_valid) begin
                    if_valid_d                  = 1'b1;
                    if_id_d[c_INS_HI:c_INS_LO]  = 32'h0;
                    if_id_d[c_PC_HI:c_PC_LO]    = pc_q;
                    if_adel_d                   = 1'b1;
                    adel_sent_d                 = 1'b1;
                end
            end
            S_WAIT: begin
                if (fetch.inst_data_ok) begin
                    state_d = S_REQ;
                    if (!w_redir_valid) begin
                        if_valid_d                 = 1'b1;
                        if_id_d[c_INS_HI:c_INS_LO] = fetch.inst_rdata;
                        if_id_d[c_PC_HI:c_PC_LO]   = pc_q;
                        if_adel_d                  = 1'b0;
                        pc_d                       = pc_q + 30'd1;
                    end
                end else if (w_redir_valid) begin
                    state_d = S_CANCEL;
                end
            end
            S_CANCEL: begin
                if (fetch.inst_data_ok) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // A redirect flushes the buffer even when decode takes it this cycle
        if (w_redir_valid) begin
            pc_d        = w_redir_target;
            if_valid_d  = 1'b0;
            misalign_d  = w_redir_misalign;
            adel_sent_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_id_q     <= '0;
            if_adel_q   <= 1'b0;
            misalign_q  <= 1'b0;
            adel_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_valid_q  <= if_valid_d;
            if_id_q     <= if_id_d;
            if_adel_q   <= if_adel_d;
            misalign_q  <= misalign_d;
            adel_sent_q <= adel_sent_d;
        end
    end

    assign fetch.inst_req  = w_inst_req;
    assign fetch.inst_addr = {pc_q, 2'b00};
    assign fetch.if_valid  = if_valid_q;
    assign fetch.IF_ID_BUS = if_id_q;
    assign fetch.if_adel   = if_adel_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with an instruction-stream
//               reference model and a randomized memory / decode environment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [29:0] TB_RESET_PC = 30'h2FF00000;
    localparam logic [29:0] TB_EXC_PC   = 30'h2FF000E0;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if fif ();

    fetch_stage #(
        .RESET_PC (TB_RESET_PC),
        .EXC_PC   (TB_EXC_PC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .fetch  (fif.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    // memory responder
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;
    int          ack_pct  = 100;
    int          dly_min  = 1;
    int          dly_max  = 1;
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_word = 32'h24010001;

    // per-cycle samples
    logic        s_req, s_hs, s_valid, s_adel, s_data_ok;
    logic [31:0] s_addr;
    logic [61:0] s_bus;

    // reference model: the instruction stream decode should see
    logic [29:0] exp_pc = TB_RESET_PC;
    bit          exp_mis = 1'b0;
    bit          exp_mis_done = 1'b0;
    int          n_consumed = 0;
    bit          prev_hold = 1'b0;
    logic [61:0] prev_bus;
    logic        prev_adel;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (fixed_en) return fixed_word;
        return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    task automatic clear_redirects();
        fif.br_valid   = 1'b0;
        fif.exc_valid  = 1'b0;
        fif.eret_valid = 1'b0;
    endtask

    // Drive memory, sample at negedge+1, update the model, advance one clock.
    task automatic next_cycle();
        logic any_redir;
        fif.inst_data_ok = 1'b0;
        fif.inst_rdata   = 32'h0;
        if (mem_busy && mem_cnt == 0) begin
            fif.inst_data_ok = 1'b1;
            fif.inst_rdata   = mem_word(mem_addr);
        end
        fif.inst_addr_ok = ($urandom_range(0, 99) < ack_pct);
        #1;
        s_req     = fif.inst_req;
        s_addr    = fif.inst_addr;
        s_valid   = fif.if_valid;
        s_bus     = fif.IF_ID_BUS;
        s_adel    = fif.if_adel;
        s_data_ok = fif.inst_data_ok;
        s_hs      = s_req & fif.inst_addr_ok;
        any_redir = resetn && (fif.exc_valid || fif.eret_valid || fif.br_valid);
        if (resetn) begin
            if (s_hs) begin
                n_cmp++;
                if (mem_busy) begin
                    n_err++;
                    $display("FAIL single_outstanding: request at %h while one is pending", s_addr);
                end
            end
            if (prev_hold) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_bus !== prev_bus || s_adel !== prev_adel) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%b bus=%h adel=%b, required 1 %h %b",
                             s_valid, s_bus, s_adel, prev_bus, prev_adel);
                end
            end
            if (s_valid && !fif.id_allowin) begin
                n_cmp++;
                if (s_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_no_req: inst_req=%b required 0", s_req);
                end
            end
            if (s_valid && fif.id_allowin) begin
                n_cmp++;
                n_consumed++;
                if (exp_mis) begin
                    if (exp_mis_done) begin
                        n_err++;
                        $display("FAIL adel_extra: entry %h delivered after address-error entry", s_bus);
                    end else if (s_bus !== {32'h0, exp_pc} || s_adel !== 1'b1) begin
                        n_err++;
                        $display("FAIL adel_entry: bus=%h adel=%b, required %h 1", s_bus, s_adel, {32'h0, exp_pc});
                    end
                    exp_mis_done = 1'b1;
                end else begin
                    if (s_bus !== {mem_word({exp_pc, 2'b00}), exp_pc} || s_adel !== 1'b0) begin
                        n_err++;
                        $display("FAIL stream: bus=%h adel=%b, required %h 0",
                                 s_bus, s_adel, {mem_word({exp_pc, 2'b00}), exp_pc});
                    end
                    exp_pc = exp_pc + 30'd1;
                end
            end
            if (any_redir) begin
                exp_mis = 1'b0;
                if (fif.exc_valid) begin
                    exp_pc = TB_EXC_PC;
                end else if (fif.eret_valid) begin
                    exp_pc  = fif.epc[31:2];
                    exp_mis = (fif.epc[1:0] != 2'b00);
                end else begin
                    exp_pc = fif.br_target;
                end
                exp_mis_done = 1'b0;
            end
        end else begin
            exp_pc       = TB_RESET_PC;
            exp_mis      = 1'b0;
            exp_mis_done = 1'b0;
        end
        prev_hold = resetn && s_valid && !fif.id_allowin && !any_redir;
        prev_bus  = s_bus;
        prev_adel = s_adel;
        @(posedge clk);
        if (!resetn) begin
            mem_busy = 1'b0;
        end else begin
            if (fif.inst_data_ok) mem_busy = 1'b0;
            else if (mem_busy && mem_cnt > 0) mem_cnt--;
            if (s_hs) begin
                mem_busy = 1'b1;
                mem_addr = s_addr;
                mem_cnt  = $urandom_range(dly_min, dly_max) - 1;
            end
        end
        @(negedge clk);
    endtask

    // Let any outstanding fetch finish and park the DUT in REQ.
    task automatic settle();
        ack_pct = 0;
        for (int i = 0; i < 10 && mem_busy; i++) next_cycle();
        n_cmp++;
        if (mem_busy) begin
            n_err++;
            $display("FAIL settle_timeout: memory still busy=%b required 0", mem_busy);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        resetn         = 1'b0;
        fif.id_allowin = 1'b1;
        fif.br_target  = 30'h123;
        fif.epc        = 32'h0;
        clear_redirects();
        fif.br_valid   = 1'b1;
        ack_pct        = 100;
        fixed_en       = 1'b1;
        next_cycle();
        n_cmp++;
        if (s_req !== 1'b0) begin n_err++; $display("FAIL reset_req: %b required 0", s_req); end
        n_cmp++;
        if (s_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: %b required 0", s_valid); end
        n_cmp++;
        if (s_bus !== 62'h0) begin n_err++; $display("FAIL reset_bus: %h required 0", s_bus); end
        n_cmp++;
        if (s_adel !== 1'b0) begin n_err++; $display("FAIL reset_adel: %b required 0", s_adel); end
        next_cycle();
        clear_redirects();
        resetn = 1'b1;
    endtask

    task automatic test_first_fetch();
        next_cycle();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'hBFC00000) begin
            n_err++; $display("FAIL first_addr: req=%b addr=%h required 1 bfc00000", s_req, s_addr);
        end
        next_cycle();
        n_cmp++;
        if (s_valid !== 1'b0 || s_req !== 1'b0) begin
            n_err++; $display("FAIL first_wait: valid=%b req=%b required 0 0", s_valid, s_req);
        end
        next_cycle();
        n_cmp++;
        if (s_valid !== 1'b1 || s_bus !== {32'h24010001, 30'h2FF00000}) begin
            n_err++; $display("FAIL first_entry: valid=%b bus=%h required 1 %h", s_valid, s_bus, {32'h24010001, 30'h2FF00000});
        end
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'hBFC00004) begin
            n_err++; $display("FAIL second_addr: req=%b addr=%h required 1 bfc00004", s_req, s_addr);
        end
        fixed_en = 1'b0;
    endtask

    task automatic test_stall();
        logic [61:0] held;
        fif.id_allowin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if (s_valid) break;
        end
        n_cmp++;
        if (s_valid !== 1'b1) begin n_err++; $display("FAIL stall_fill: valid=%b required 1", s_valid); end
        held = s_bus;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            n_cmp++;
            if (s_req !== 1'b0 || s_bus !== held) begin
                n_err++; $display("FAIL stall_cycle: req=%b bus=%h required 0 %h", s_req, s_bus, held);
            end
        end
        fif.id_allowin = 1'b1;
        next_cycle();
        n_cmp++;
        if (s_req !== 1'b1) begin n_err++; $display("FAIL stall_release: req=%b required 1", s_req); end
    endtask

    task automatic test_branch_wait();
        bit seen;
        dly_min = 4;
        dly_max = 4;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if (s_hs) break;
        end
        fif.br_valid  = 1'b1;
        fif.br_target = 30'h00000100;
        next_cycle();
        clear_redirects();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            next_cycle();
            seen = s_data_ok;
            n_cmp++;
            if (s_valid !== 1'b0) begin n_err++; $display("FAIL br_drop_valid: valid=%b required 0", s_valid); end
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL br_data_timeout: data_ok=%b required 1", seen); end
        dly_min = 1;
        dly_max = 1;
        next_cycle();
        n_cmp++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h00000400) begin
            n_err++; $display("FAIL br_target_addr: valid=%b req=%b addr=%h required 0 1 00000400", s_valid, s_req, s_addr);
        end
    endtask

    task automatic test_priority();
        settle();
        fif.exc_valid  = 1'b1;
        fif.eret_valid = 1'b1;
        fif.epc        = 32'h80001000;
        fif.br_valid   = 1'b1;
        fif.br_target  = 30'h00000055;
        next_cycle();
        clear_redirects();
        ack_pct = 100;
        next_cycle();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'hBFC00380) begin
            n_err++; $display("FAIL priority_addr: req=%b addr=%h required 1 bfc00380", s_req, s_addr);
        end
    endtask

    task automatic test_misaligned_eret();
        int saw;
        settle();
        fif.eret_valid = 1'b1;
        fif.epc        = 32'h80001002;
        next_cycle();
        clear_redirects();
        ack_pct = 100;
        saw = 0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            n_cmp++;
            if (s_req !== 1'b0) begin n_err++; $display("FAIL mis_req: req=%b addr=%h required 0", s_req, s_addr); end
            if (s_valid) begin
                saw++;
                n_cmp++;
                if (s_adel !== 1'b1 || s_bus[29:0] !== 30'h20000400 || s_bus[61:30] !== 32'h0) begin
                    n_err++; $display("FAIL mis_entry: adel=%b bus=%h required 1 %h", s_adel, s_bus, {32'h0, 30'h20000400});
                end
            end
        end
        n_cmp++;
        if (saw != 1) begin n_err++; $display("FAIL mis_count: entries=%0d required 1", saw); end
    endtask

    task automatic test_wrap();
        fif.br_valid  = 1'b1;
        fif.br_target = 30'h3FFFFFFF;
        next_cycle();
        clear_redirects();
        next_cycle();
        n_cmp++;
        if (s_hs !== 1'b1 || s_addr !== 32'hFFFFFFFC) begin
            n_err++; $display("FAIL wrap_req: hs=%b addr=%h required 1 fffffffc", s_hs, s_addr);
        end
        next_cycle();
        next_cycle();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h00000000) begin
            n_err++; $display("FAIL wrap_next: req=%b addr=%h required 1 00000000", s_req, s_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        dly_min = 3;
        dly_max = 3;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if (s_hs) break;
        end
        next_cycle();
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (fif.if_valid !== 1'b0 || fif.IF_ID_BUS !== 62'h0 || fif.if_adel !== 1'b0 || fif.inst_req !== 1'b0) begin
            n_err++; $display("FAIL async_reset: valid=%b bus=%h adel=%b req=%b required all 0",
                              fif.if_valid, fif.IF_ID_BUS, fif.if_adel, fif.inst_req);
        end
        mem_busy  = 1'b0;
        prev_hold = 1'b0;
        dly_min   = 1;
        dly_max   = 1;
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'hBFC00000) begin
            n_err++; $display("FAIL reset_restart: req=%b addr=%h required 1 bfc00000", s_req, s_addr);
        end
    endtask

    task automatic test_random();
        int unsigned r;
        logic [31:0] rv;
        ack_pct    = 60;
        dly_min    = 1;
        dly_max    = 3;
        n_consumed = 0;
        for (int i = 0; i < 2000; i++) begin
            fif.id_allowin = ($urandom_range(0, 99) < 70);
            clear_redirects();
            r  = $urandom_range(0, 99);
            rv = $urandom();
            if (r < 3) begin
                fif.br_valid  = 1'b1;
                fif.br_target = rv[29:0];
            end else if (r == 3) begin
                fif.exc_valid = 1'b1;
            end else if (r == 4) begin
                fif.eret_valid = 1'b1;
                fif.epc        = {rv[31:2], 2'b00};
            end else if (r == 5) begin
                fif.eret_valid = 1'b1;
                fif.epc        = {rv[31:2], 2'b10};
            end else if (r == 6) begin
                fif.exc_valid  = rv[0];
                fif.eret_valid = rv[1];
                fif.br_valid   = 1'b1;
                fif.epc        = rv;
                fif.br_target  = ~rv[29:0];
            end
            next_cycle();
        end
        clear_redirects();
        n_cmp++;
        if (n_consumed < 150) begin
            n_err++; $display("FAIL random_progress: consumed=%0d required >=150", n_consumed);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch_wait();
        test_priority();
        test_misaligned_eret();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; sole writer of IF_ID_BUS ({ins[31:0], pc[29:0]}, 62 bits), which the decode stage consumes.
- Holds the word-addressed PC and drives a single-outstanding request/response instruction-memory port.
- Applies branch/jump, exception and ERET redirects, and buffers one fetched word until decode accepts it.

Parameters:
- RESET_PC, 30'h2FF00000, word address of the reset vector (byte 0xBFC00000).
- EXC_PC, 30'h2FF000E0, word address of the exception vector (byte 0xBFC00380).

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous active-low reset.
- inst_req  out  1  fetch request valid.
- inst_addr  out  32  byte address of the request, {pc_q, 2'b00}.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_rdata  in  32  instruction word.
- inst_data_ok  in  1  inst_rdata valid this cycle.
- br_valid  in  1  branch/jump taken, resolved in EXE.
- br_target  in  30  branch/jump word target.
- exc_valid  in  1  exception commit.
- eret_valid  in  1  ERET commit.
- epc  in  32  return byte address for ERET.
- id_allowin  in  1  decode accepts IF_ID_BUS this cycle.
- if_valid  out  1  IF_ID_BUS holds a valid instruction.
- IF_ID_BUS  out  62  {ins, pc}.
- if_adel  out  1  address-error flag; qualified by if_valid.

Behaviour:
- Reset (async, resetn=0):
  - pc_q = RESET_PC, FSM = REQ.
  - if_valid = 0, IF_ID_BUS = 0, if_adel = 0.
  - inst_req is low while reset is asserted.
- FSM states REQ, WAIT, CANCEL. At most one request is outstanding. The output buffer is one entry (if_valid).
- REQ:
  - inst_req = 1 only when !if_valid or (if_valid & id_allowin).
  - inst_req & inst_addr_ok -> WAIT. The address is latched and pc_q is unchanged until data returns.
- WAIT:
  - inst_req = 0.
  - On inst_data_ok: buffer <= {inst_rdata, pc_q}, if_valid <= 1, pc_q <= pc_q + 1, -> REQ.
  - pc_q + 1 is 30-bit and wraps 30'h3FFFFFFF -> 0.
- CANCEL:
  - inst_req = 0.
  - On inst_data_ok the word is discarded (no buffer write), -> REQ.
- Buffer handshake:
  - if_valid & id_allowin -> the entry is consumed. If no write happens the same cycle, if_valid <= 0.
  - While if_valid & !id_allowin, IF_ID_BUS and if_adel are held bit-stable.
  - Issue rule guarantees data_ok never arrives into a full, stalled buffer.
- Latency: addr_ok cycle N, data_ok cycle N+1 -> if_valid at N+2. Best-case throughput is one instruction per 2 cycles.
- Redirects:
  - Priority exc_valid > eret_valid > br_valid. Targets are EXC_PC, epc[31:2], br_target.
  - Any redirect: pc_q <= target, if_valid <= 0. The buffer is flushed even if decode is accepting it that cycle; decode treats an accepted word as its own.
  - Redirect in REQ with no handshake -> stay REQ at the new PC.
  - Redirect in REQ with inst_req & inst_addr_ok the same cycle -> CANCEL.
  - Redirect in WAIT without data_ok -> CANCEL. With data_ok -> data dropped, -> REQ.
  - Redirect in CANCEL -> pc_q updated, stay CANCEL.
- Misaligned ERET (epc[1:0] != 0):
  - pc_q <= epc[31:2]; no memory request for it.
  - The next buffer entry is {32'h0, pc_q} with if_adel = 1, produced directly from REQ one cycle after the redirect.
  - Fetching then stalls in REQ, with pc_q held, until the next redirect.
- Simultaneous consume and fill: if_valid stays 1 and the new entry replaces the old one.
- A redirect raised during reset is ignored.

Decomposition:
- Shared package: RESET_PC/EXC_PC constants, IF_ID_BUS width (62) and field offsets (INS_HI=61, INS_LO=30, PC_HI=29, PC_LO=0), FSM state enum.
- Redirect priority mux as sub-module fetch_redirect_sel, which outputs redirect valid, target and misalign flag. Everything else stays flat.

Test Plan:
- Reset release, memory replying addr_ok immediately and data_ok next cycle with 32'h24010001, id_allowin=1 -> inst_addr=32'hBFC00000; IF_ID_BUS={32'h24010001, 30'h2FF00000}, if_valid=1 two cycles after the first request; next inst_addr=32'hBFC00004.
- id_allowin=0 for 5 cycles with buffer full -> IF_ID_BUS stable, inst_req=0 throughout; on release, the next request goes out the same cycle.
- br_valid with br_target=30'h00000100 while in WAIT, data_ok 3 cycles later -> returned word dropped, no if_valid; next inst_addr=32'h00000400.
- exc_valid, eret_valid (epc=32'h80001000) and br_valid in the same cycle -> next inst_addr=32'hBFC00380.
- eret_valid with epc=32'h80001002 -> no request issued; if_valid=1, if_adel=1, pc field 30'h20000400.
- pc_q=30'h3FFFFFFF fetch completes -> next inst_addr=32'h00000000; resetn pulsed low mid-WAIT -> outputs clear immediately and inst_addr=32'hBFC00000 after release.
